// File: rtl/contador_updown_param_pkg.sv
// Shared definitions for the microwave timer counters: limit-mode encodings,
// default count limits and the step decode used by the counter core.
package contador_updown_param_pkg;

    localparam logic MODE_SAT  = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    localparam int unsigned DEF_MIN_VAL = 32'd0;
    localparam int unsigned DEF_MAX_VAL = 32'd21;

    typedef enum logic [2:0] {
        STEP_HOLD    = 3'd0,
        STEP_INC     = 3'd1,
        STEP_DEC     = 3'd2,
        STEP_WRAP_LO = 3'd3,
        STEP_WRAP_HI = 3'd4,
        STEP_LOAD    = 3'd5
    } step_e;

endpackage

// File: rtl/contador_updown_param_divisor_tick.sv
// Prescaler producing a registered one-cycle strobe every DIV enabled cycles.
// The phase freezes while en is low.
module divisor_tick #(
    parameter int unsigned DIV = 32'd50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
    localparam logic [CW-1:0] LAST  = CW'(DIV - 32'd1);
    localparam logic [CW-1:0] ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] presc_r;
    logic          tick_r;

    // Prescaler phase and registered step strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= ZERO;
            tick_r  <= 1'b0;
        end else if (en) begin
            if (presc_r == LAST) begin
                presc_r <= ZERO;
                tick_r  <= 1'b1;
            end else begin
                presc_r <= presc_r + ONE_C;
                tick_r  <= 1'b0;
            end
        end else begin
            presc_r <= presc_r;
            tick_r  <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/contador_updown_param.sv
// Parametrised up/down counter with clamped synchronous load, tick-enabled
// stepping and selectable saturate/wrap behaviour at the limits.
module contador_updown_param
    import contador_updown_param_pkg::*;
#(
    parameter int unsigned WIDTH   = 32'd8,
    parameter int unsigned MIN_VAL = DEF_MIN_VAL,
    parameter int unsigned MAX_VAL = DEF_MAX_VAL,
    parameter int unsigned DIV     = 32'd50_000_000,
    parameter logic        WRAP    = MODE_SAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             updown,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             at_max,
    output logic             at_min,
    output logic             wrapped
);

    // One extra bit keeps MAX_VAL = 2**WIDTH-1 from overflowing in compares.
    localparam int unsigned      XW    = WIDTH + 32'd1;
    localparam logic [XW-1:0]    MIN_X = XW'(MIN_VAL);
    localparam logic [XW-1:0]    MAX_X = XW'(MAX_VAL);
    localparam logic [XW-1:0]    ONE_X = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic             tick_s;
    logic [XW-1:0]    count_x_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;
    logic             wrapped_r;
    logic             wrapped_next_s;
    step_e            step_s;

    function automatic logic [WIDTH-1:0] clamp_val(input logic [WIDTH-1:0] v);
        logic [XW-1:0]    vx;
        logic [WIDTH-1:0] res;
        vx = {1'b0, v};
        if (vx > MAX_X) begin
            res = MAX_W;
        end else if (vx < MIN_X) begin
            res = MIN_W;
        end else begin
            res = v;
        end
        return res;
    endfunction

    divisor_tick #(
        .DIV (DIV)
    ) u_divisor_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick_s)
    );

    assign count_x_s = {1'b0, count_r};

    // Decide what happens to the count at the next edge; load beats a step.
    always_comb begin
        step_s = STEP_HOLD;
        if (load) begin
            step_s = STEP_LOAD;
        end else if (tick_s) begin
            if (updown) begin
                if (count_x_s < MAX_X) begin
                    step_s = STEP_INC;
                end else if (WRAP == MODE_WRAP) begin
                    step_s = STEP_WRAP_LO;
                end else begin
                    step_s = STEP_HOLD;
                end
            end else begin
                if (count_x_s > MIN_X) begin
                    step_s = STEP_DEC;
                end else if (WRAP == MODE_WRAP) begin
                    step_s = STEP_WRAP_HI;
                end else begin
                    step_s = STEP_HOLD;
                end
            end
        end else begin
            step_s = STEP_HOLD;
        end
    end

    // Next count and wrap pulse for the chosen step.
    always_comb begin
        count_next_s   = count_r;
        wrapped_next_s = 1'b0;
        case (step_s)
            STEP_LOAD:    count_next_s = clamp_val(load_val);
            STEP_INC:     count_next_s = WIDTH'(count_x_s + ONE_X);
            STEP_DEC:     count_next_s = WIDTH'(count_x_s - ONE_X);
            STEP_WRAP_LO: begin
                count_next_s   = MIN_W;
                wrapped_next_s = 1'b1;
            end
            STEP_WRAP_HI: begin
                count_next_s   = MAX_W;
                wrapped_next_s = 1'b1;
            end
            default: begin
                count_next_s   = count_r;
                wrapped_next_s = 1'b0;
            end
        endcase
    end

    // Count and wrap-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r   <= MIN_W;
            wrapped_r <= 1'b0;
        end else begin
            count_r   <= count_next_s;
            wrapped_r <= wrapped_next_s;
        end
    end

    assign count   = count_r;
    assign tick    = tick_s;
    assign wrapped = wrapped_r;
    assign at_max  = (count_x_s == MAX_X);
    assign at_min  = (count_x_s == MIN_X);

endmodule

// File: tb/tb_contador_updown_param.sv
// Scoreboard bench for contador_updown_param: five parameterisations share one
// stimulus stream; expectations are cycle-stamped and checked by a monitor.
module tb_contador_updown_param;
    import contador_updown_param_pkg::*;

    typedef struct {
        string       name;
        int          cyc;
        int          inst;
        logic [11:0] exp;
    } sb_t;

    sb_t sb_q[$];

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       en       = 1'b0;
    logic       updown   = 1'b1;
    logic       load     = 1'b0;
    logic [7:0] load_val = 8'd0;

    logic [7:0] cnt_w  [5];
    logic       tick_w [5];
    logic       wr_w   [5];
    logic       amax_w [5];
    logic       amin_w [5];

    int cyc      = 0;
    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: saturating 0..21, 1: wrapping 0..21, 2: MIN 3, 3: MIN 10, 4: DIV 1 wrapping 0..255
    contador_updown_param #(.WIDTH(32'd8), .MIN_VAL(32'd0), .MAX_VAL(32'd21), .DIV(32'd4), .WRAP(MODE_SAT))
    u_sat (.clk(clk), .rst(rst), .en(en), .updown(updown), .load(load), .load_val(load_val),
           .count(cnt_w[0]), .tick(tick_w[0]), .at_max(amax_w[0]), .at_min(amin_w[0]), .wrapped(wr_w[0]));
    contador_updown_param #(.WIDTH(32'd8), .MIN_VAL(32'd0), .MAX_VAL(32'd21), .DIV(32'd4), .WRAP(MODE_WRAP))
    u_wrap (.clk(clk), .rst(rst), .en(en), .updown(updown), .load(load), .load_val(load_val),
            .count(cnt_w[1]), .tick(tick_w[1]), .at_max(amax_w[1]), .at_min(amin_w[1]), .wrapped(wr_w[1]));
    contador_updown_param #(.WIDTH(32'd8), .MIN_VAL(32'd3), .MAX_VAL(32'd21), .DIV(32'd4), .WRAP(MODE_SAT))
    u_min3 (.clk(clk), .rst(rst), .en(en), .updown(updown), .load(load), .load_val(load_val),
            .count(cnt_w[2]), .tick(tick_w[2]), .at_max(amax_w[2]), .at_min(amin_w[2]), .wrapped(wr_w[2]));
    contador_updown_param #(.WIDTH(32'd8), .MIN_VAL(32'd10), .MAX_VAL(32'd21), .DIV(32'd4), .WRAP(MODE_SAT))
    u_min10 (.clk(clk), .rst(rst), .en(en), .updown(updown), .load(load), .load_val(load_val),
             .count(cnt_w[3]), .tick(tick_w[3]), .at_max(amax_w[3]), .at_min(amin_w[3]), .wrapped(wr_w[3]));
    contador_updown_param #(.WIDTH(32'd8), .MIN_VAL(32'd0), .MAX_VAL(32'd255), .DIV(32'd1), .WRAP(MODE_WRAP))
    u_div1 (.clk(clk), .rst(rst), .en(en), .updown(updown), .load(load), .load_val(load_val),
            .count(cnt_w[4]), .tick(tick_w[4]), .at_max(amax_w[4]), .at_min(amin_w[4]), .wrapped(wr_w[4]));

    function automatic logic [11:0] obs(input int k);
        return {cnt_w[k], tick_w[k], wr_w[k], amax_w[k], amin_w[k]};
    endfunction

    task automatic push(input string nm, input int at, input int inst,
                        input int cnt, input bit tk, input bit wr);
        sb_t e;
        int  mn;
        int  mx;
        mx = (inst == 4) ? 255 : 21;
        mn = (inst == 2) ? 3 : ((inst == 3) ? 10 : 0);
        e.name = nm;
        e.cyc  = at;
        e.inst = inst;
        e.exp  = {8'(cnt), tk, wr, (cnt == mx), (cnt == mn)};
        sb_q.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(output int r);
        @(posedge clk);
        #1;
        rst = 1'b1; en = 1'b0; load = 1'b0; updown = 1'b1; load_val = 8'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        r = cyc;
    endtask

    // Monitor: every cycle, compare all expectations stamped for this cycle.
    always @(negedge clk) begin : monitor
        logic [11:0] act;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc <= cyc) begin
                act = obs(sb_q[i].inst);
                chk_cnt++;
                if (sb_q[i].cyc == cyc && act === sb_q[i].exp) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL %s cyc=%0d(due %0d) inst=%0d got count=%0d tick=%b wrapped=%b at_max=%b at_min=%b want count=%0d tick=%b wrapped=%b at_max=%b at_min=%b",
                             sb_q[i].name, cyc, sb_q[i].cyc, sb_q[i].inst,
                             act[11:4], act[3], act[2], act[1], act[0],
                             sb_q[i].exp[11:4], sb_q[i].exp[3], sb_q[i].exp[2], sb_q[i].exp[1], sb_q[i].exp[0]);
                end
                sb_q.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int c;
        repeat (2) @(posedge clk);
        #1;

        // Count up from reset, saturating at 21.
        do_reset(r);
        en = 1'b1; updown = 1'b1;
        push("rst_min3", r, 2, 3, 1'b0, 1'b0);
        push("rst_div1", r, 4, 0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            c = (i == 0) ? 0 : (i - 1) / 4;
            if (c > 21) c = 21;
            push("t1_up_sat", r + i, 0, c, (i > 0 && i % 4 == 0), 1'b0);
        end
        goto(r + 100);

        // Wrap up 21->0 and down 0->21.
        do_reset(r);
        load = 1'b1; load_val = 8'd20;
        push("t2_load",     r + 1,  1, 20, 1'b0, 1'b0);
        push("t2_tick1",    r + 5,  1, 20, 1'b1, 1'b0);
        push("t2_to21",     r + 6,  1, 21, 1'b0, 1'b0);
        push("t2_tick2",    r + 9,  1, 21, 1'b1, 1'b0);
        push("t2_wrap_up",  r + 10, 1, 0,  1'b0, 1'b1);
        push("t2_sat_hold", r + 10, 0, 21, 1'b0, 1'b0);
        push("t2_wr_clr",   r + 11, 1, 0,  1'b0, 1'b0);
        push("t2_tick3",    r + 13, 1, 0,  1'b1, 1'b0);
        push("t2_wrap_dn",  r + 14, 1, 21, 1'b0, 1'b1);
        push("t2_wr_clr2",  r + 15, 1, 21, 1'b0, 1'b0);
        goto(r + 1);
        load = 1'b0; en = 1'b1; updown = 1'b1;
        goto(r + 10);
        updown = 1'b0;
        goto(r + 16);
        en = 1'b0;

        // Load clamping against MAX and MIN.
        do_reset(r);
        load = 1'b1; load_val = 8'd200;
        push("t3_200_sat",   r + 1, 0, 21, 1'b0, 1'b0);
        push("t3_200_min3",  r + 1, 2, 21, 1'b0, 1'b0);
        push("t3_200_min10", r + 1, 3, 21, 1'b0, 1'b0);
        push("t3_5_sat",     r + 2, 0, 5,  1'b0, 1'b0);
        push("t3_5_min3",    r + 2, 2, 5,  1'b0, 1'b0);
        push("t3_5_min10",   r + 2, 3, 10, 1'b0, 1'b0);
        push("t3_2_sat",     r + 3, 0, 2,  1'b0, 1'b0);
        push("t3_2_min3",    r + 3, 2, 3,  1'b0, 1'b0);
        push("t3_2_min10",   r + 3, 3, 10, 1'b0, 1'b0);
        goto(r + 1);
        load_val = 8'd5;
        goto(r + 2);
        load_val = 8'd2;
        goto(r + 3);
        load = 1'b0;

        // Load coincident with tick wins; prescaler phase untouched.
        do_reset(r);
        en = 1'b1;
        push("t4_tick",      r + 4, 0, 0, 1'b1, 1'b0);
        push("t4_load7",     r + 5, 0, 7, 1'b0, 1'b0);
        push("t4_next_tick", r + 8, 0, 7, 1'b1, 1'b0);
        push("t4_step8",     r + 9, 0, 8, 1'b0, 1'b0);
        goto(r + 4);
        load = 1'b1; load_val = 8'd7;
        goto(r + 5);
        load = 1'b0;
        goto(r + 10);

        // en low for 10 cycles with the prescaler at 2.
        do_reset(r);
        en = 1'b1;
        for (int k = 3; k <= 13; k++) push("t5_frozen", r + k, 0, 0, 1'b0, 1'b0);
        push("t5_tick", r + 14, 0, 0, 1'b1, 1'b0);
        push("t5_step", r + 15, 0, 1, 1'b0, 1'b0);
        goto(r + 2);
        en = 1'b0;
        goto(r + 12);
        en = 1'b1;
        goto(r + 16);

        // Reset while tick is high at count 9.
        do_reset(r);
        load = 1'b1; load_val = 8'd9;
        push("t6_load9",      r + 1,  0, 9, 1'b0, 1'b0);
        push("t6_tick",       r + 5,  0, 9, 1'b1, 1'b0);
        push("t6_rst",        r + 6,  0, 0, 1'b0, 1'b0);
        push("t6_no_early",   r + 9,  0, 0, 1'b0, 1'b0);
        push("t6_tick_again", r + 10, 0, 0, 1'b1, 1'b0);
        push("t6_step",       r + 11, 0, 1, 1'b0, 1'b0);
        goto(r + 1);
        load = 1'b0; en = 1'b1;
        goto(r + 5);
        rst = 1'b1;
        goto(r + 6);
        rst = 1'b0;
        goto(r + 12);

        // DIV = 1, full 8-bit range wrap 255->0.
        do_reset(r);
        load = 1'b1; load_val = 8'd253;
        push("t6b_load",  r + 1, 4, 253, 1'b0, 1'b0);
        push("t6b_tick",  r + 2, 4, 253, 1'b1, 1'b0);
        push("t6b_254",   r + 3, 4, 254, 1'b1, 1'b0);
        push("t6b_255",   r + 4, 4, 255, 1'b1, 1'b0);
        push("t6b_wrap0", r + 5, 4, 0,   1'b1, 1'b1);
        push("t6b_1",     r + 6, 4, 1,   1'b1, 1'b0);
        goto(r + 1);
        load = 1'b0; en = 1'b1; updown = 1'b1;
        goto(r + 7);
        en = 1'b0;

        goto(cyc + 2);
        if (sb_q.size() != 0) begin
            $display("FAIL leftover_expectations got %0d pending want 0", sb_q.size());
            chk_cnt = chk_cnt + sb_q.size();
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
